// File: rtl/wb_traffic_gen_if.sv
// Wishbone master/slave bundle for the traffic generator.
// Signal names follow the sdrc_top slave port they connect to.
interface wb_traffic_gen_if #(
    parameter int DW = 32,
    parameter int AW = 26
);
    logic            wb_cyc_o;
    logic            wb_stb_o;
    logic            wb_we_o;
    logic [AW-1:0]   wb_addr_o;
    logic [DW-1:0]   wb_dat_o;
    logic [DW/8-1:0] wb_sel_o;
    logic [2:0]      wb_cti_o;
    logic            wb_ack_i;
    logic [DW-1:0]   wb_dat_i;

    modport master (
        output wb_cyc_o, wb_stb_o, wb_we_o, wb_addr_o,
        output wb_dat_o, wb_sel_o, wb_cti_o,
        input  wb_ack_i, wb_dat_i
    );

    modport slave (
        input  wb_cyc_o, wb_stb_o, wb_we_o, wb_addr_o,
        input  wb_dat_o, wb_sel_o, wb_cti_o,
        output wb_ack_i, wb_dat_i
    );
endinterface

// File: rtl/wb_traffic_gen.sv
// Wishbone burst traffic generator and readback checker.
// Writes an address or LFSR pattern, then reads it back and counts mismatches.
module wb_traffic_gen #(
    parameter int DW     = 32,
    parameter int AW     = 26,
    parameter int BL_W   = 4,
    parameter int TO_CYC = 1024
) (
    input  logic             wb_clk_i,
    input  logic             wb_rst_i,
    wb_traffic_gen_if.master wb,
    input  logic             start,
    input  logic [1:0]       mode,
    input  logic             pattern,
    input  logic [31:0]      seed,
    input  logic [AW-1:0]    base_addr,
    input  logic [BL_W-1:0]  burst_len,
    input  logic [15:0]      num_bursts,
    output logic             busy,
    output logic             done,
    output logic             timeout,
    output logic [15:0]      err_cnt,
    output logic [AW-1:0]    first_err_addr
);
    localparam int NW   = DW / 32;
    localparam int STEP = DW / 8;
    localparam int TW   = $clog2(TO_CYC + 1);
    localparam logic [AW-1:0] AMASK = ~AW'(STEP - 1);

    typedef enum logic [2:0] {
        IDLE, WR_BEAT, WR_GAP, RD_BEAT, RD_GAP, DONE
    } state_t;

    state_t          state;
    logic [1:0]      mode_r;
    logic            pat_r;
    logic [31:0]     seed_r;
    logic [AW-1:0]   base_r;
    logic [BL_W-1:0] blen_r;
    logic [15:0]     nb_r;
    logic [BL_W-1:0] beat_cnt;
    logic [15:0]     burst_cnt;
    logic [31:0]     lfsr_r;
    logic [TW-1:0]   to_cnt;

    // Galois form of x^32+x^22+x^2+x+1, shifting toward the MSB
    function automatic logic [31:0] lfsr_step(input logic [31:0] s);
        return {s[30:0], 1'b0} ^ (s[31] ? 32'h0040_0007 : 32'h0);
    endfunction

    function automatic logic [31:0] lfsr_adv(input logic [31:0] s);
        logic [31:0] l;
        l = s;
        for (int k = 0; k < NW; k++) l = lfsr_step(l);
        return l;
    endfunction

    function automatic logic [DW-1:0] gen_beat(
        input logic [AW-1:0] a,
        input logic [31:0]   s,
        input logic          p
    );
        logic [DW-1:0] d;
        logic [31:0]   l;
        d = '0;
        l = s;
        for (int k = 0; k < NW; k++) begin
            d[32*k +: 32] = p ? l : 32'(a);
            l = lfsr_step(l);
        end
        return d;
    endfunction

    logic [AW-1:0]   addr_nxt;
    logic [31:0]     lfsr_nxt;
    logic [DW-1:0]   cur_dat;
    logic [DW-1:0]   nxt_dat;
    logic            last_beat;
    logic            last_burst;
    logic [2:0]      first_cti;
    logic [2:0]      nxt_cti;
    logic            mismatch;
    logic [31:0]     seed_eff;
    logic [BL_W-1:0] blen_eff;

    always_comb begin
        addr_nxt   = wb.wb_addr_o + AW'(STEP);
        lfsr_nxt   = lfsr_adv(lfsr_r);
        cur_dat    = gen_beat(wb.wb_addr_o, lfsr_r, pat_r);
        nxt_dat    = gen_beat(addr_nxt, lfsr_nxt, pat_r);
        last_beat  = beat_cnt == blen_r - BL_W'(1);
        last_burst = burst_cnt == nb_r - 16'd1;
        first_cti  = (blen_r == BL_W'(1)) ? 3'b000 : 3'b010;
        nxt_cti    = (beat_cnt + BL_W'(1) == blen_r - BL_W'(1))
                   ? 3'b111 : 3'b010;
        mismatch   = wb.wb_dat_i != cur_dat;
        seed_eff   = (seed == 32'h0) ? 32'h1 : seed;
        blen_eff   = (burst_len == '0) ? BL_W'(1) : burst_len;
    end

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            state          <= IDLE;
            mode_r         <= '0;
            pat_r          <= 1'b0;
            seed_r         <= '0;
            base_r         <= '0;
            blen_r         <= '0;
            nb_r           <= '0;
            beat_cnt       <= '0;
            burst_cnt      <= '0;
            lfsr_r         <= '0;
            to_cnt         <= '0;
            wb.wb_cyc_o    <= 1'b0;
            wb.wb_stb_o    <= 1'b0;
            wb.wb_we_o     <= 1'b0;
            wb.wb_addr_o   <= '0;
            wb.wb_dat_o    <= '0;
            wb.wb_sel_o    <= '0;
            wb.wb_cti_o    <= 3'b000;
            busy           <= 1'b0;
            done           <= 1'b0;
            timeout        <= 1'b0;
            err_cnt        <= '0;
            first_err_addr <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (start) begin
                        mode_r         <= mode;
                        pat_r          <= pattern;
                        seed_r         <= seed_eff;
                        base_r         <= base_addr & AMASK;
                        blen_r         <= blen_eff;
                        nb_r           <= num_bursts;
                        lfsr_r         <= seed_eff;
                        wb.wb_addr_o   <= base_addr & AMASK;
                        beat_cnt       <= '0;
                        burst_cnt      <= '0;
                        err_cnt        <= '0;
                        first_err_addr <= '0;
                        timeout        <= 1'b0;
                        done           <= 1'b0;
                        busy           <= 1'b1;
                        if (num_bursts == 16'd0)
                            state <= DONE;
                        else if (mode == 2'd1)
                            state <= RD_BEAT;
                        else
                            state <= WR_BEAT;
                    end
                end
                WR_BEAT, RD_BEAT: begin
                    if (!wb.wb_cyc_o) begin
                        wb.wb_cyc_o <= 1'b1;
                        wb.wb_stb_o <= 1'b1;
                        wb.wb_we_o  <= state == WR_BEAT;
                        wb.wb_sel_o <= '1;
                        wb.wb_cti_o <= first_cti;
                        to_cnt      <= '0;
                        if (state == WR_BEAT) wb.wb_dat_o <= cur_dat;
                    end else if (wb.wb_ack_i) begin
                        if (state == RD_BEAT && mismatch) begin
                            if (err_cnt == 16'd0)
                                first_err_addr <= wb.wb_addr_o;
                            if (err_cnt != 16'hFFFF)
                                err_cnt <= err_cnt + 16'd1;
                        end
                        wb.wb_addr_o <= addr_nxt;
                        lfsr_r       <= lfsr_nxt;
                        to_cnt       <= '0;
                        if (last_beat) begin
                            wb.wb_cyc_o <= 1'b0;
                            wb.wb_stb_o <= 1'b0;
                            wb.wb_we_o  <= 1'b0;
                            wb.wb_sel_o <= '0;
                            wb.wb_cti_o <= 3'b000;
                            beat_cnt    <= '0;
                            if (last_burst) begin
                                burst_cnt <= '0;
                                // Read pass replays the same stream from the base
                                if (state == WR_BEAT && mode_r != 2'd0) begin
                                    state        <= RD_BEAT;
                                    wb.wb_addr_o <= base_r;
                                    lfsr_r       <= seed_r;
                                end else begin
                                    state <= DONE;
                                end
                            end else begin
                                burst_cnt <= burst_cnt + 16'd1;
                                state <= (state == WR_BEAT) ? WR_GAP : RD_GAP;
                            end
                        end else begin
                            beat_cnt    <= beat_cnt + BL_W'(1);
                            wb.wb_cti_o <= nxt_cti;
                            if (state == WR_BEAT) wb.wb_dat_o <= nxt_dat;
                        end
                    end else if (to_cnt == TW'(TO_CYC - 1)) begin
                        timeout     <= 1'b1;
                        wb.wb_cyc_o <= 1'b0;
                        wb.wb_stb_o <= 1'b0;
                        wb.wb_we_o  <= 1'b0;
                        wb.wb_sel_o <= '0;
                        wb.wb_cti_o <= 3'b000;
                        state       <= DONE;
                    end else begin
                        to_cnt <= to_cnt + TW'(1);
                    end
                end
                WR_GAP, RD_GAP: begin
                    wb.wb_cyc_o <= 1'b1;
                    wb.wb_stb_o <= 1'b1;
                    wb.wb_we_o  <= state == WR_GAP;
                    wb.wb_sel_o <= '1;
                    wb.wb_cti_o <= first_cti;
                    to_cnt      <= '0;
                    if (state == WR_GAP) wb.wb_dat_o <= cur_dat;
                    state <= (state == WR_GAP) ? WR_BEAT : RD_BEAT;
                end
                DONE: begin
                    done  <= 1'b1;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_wb_traffic_gen.sv
// Scoreboard bench for wb_traffic_gen with a memory-backed random-latency slave.
// Expected beats come from a pattern model and are checked as the slave acks them.
module tb_wb_traffic_gen;
    localparam int AW = 26;

    typedef struct {
        logic        we;
        logic [25:0] addr;
        logic [31:0] dat;
        logic [2:0]  cti;
        bit          gap;
    } beat_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic [1:0]  mode = '0;
    logic        pattern = 1'b0;
    logic [31:0] seed = '0;
    logic [25:0] base_addr = '0;
    logic [3:0]  burst_len = '0;
    logic [15:0] num_bursts = '0;
    logic        busy, done, timeout;
    logic [15:0] err_cnt;
    logic [25:0] first_err_addr;

    wb_traffic_gen_if #(.DW(32), .AW(AW)) bus ();

    wb_traffic_gen #(.DW(32), .AW(AW), .BL_W(4), .TO_CYC(16)) dut (
        .wb_clk_i       (clk),
        .wb_rst_i       (rst),
        .wb             (bus),
        .start          (start),
        .mode           (mode),
        .pattern        (pattern),
        .seed           (seed),
        .base_addr      (base_addr),
        .burst_len      (burst_len),
        .num_bursts     (num_bursts),
        .busy           (busy),
        .done           (done),
        .timeout        (timeout),
        .err_cnt        (err_cnt),
        .first_err_addr (first_err_addr)
    );

    always #5 clk = ~clk;

    int    n_chk = 0;
    int    n_fail = 0;
    beat_t exp_q[$];
    logic [31:0] mem [logic [25:0]];
    logic [31:0] ref_mem [logic [25:0]];
    bit    corrupt [logic [25:0]];
    int    ack_pct = 100;
    bit    mon_en = 1'b1;
    int    gap_st = 0;
    int    beats_seen = 0;
    int    cyc_cycles = 0;

    task automatic check(input string nm, input logic [63:0] act,
                         input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    function automatic logic [31:0] dflt(input logic [25:0] a);
        return 32'hC0DE_0000 ^ {6'b0, a};
    endfunction

    // One LFSR step = multiply by x modulo the generator polynomial
    function automatic logic [31:0] mulx(input logic [31:0] s);
        logic [32:0] t;
        t = {s, 1'b0};
        if (t[32]) t = t ^ 33'h1_0040_0007;
        return t[31:0];
    endfunction

    // Slave and monitor share the negedge so the acked beat is still on the bus
    initial begin
        beat_t e;
        bus.wb_ack_i = 1'b0;
        bus.wb_dat_i = '0;
        forever begin
            @(negedge clk);
            if (bus.wb_cyc_o) cyc_cycles++;
            if (!mon_en) gap_st = 0;
            else if (gap_st == 1) begin
                check("gap_low", 64'(bus.wb_cyc_o), 64'(0));
                gap_st = 2;
            end else if (gap_st == 2) begin
                check("gap_rise", 64'(bus.wb_cyc_o), 64'(1));
                gap_st = 0;
            end
            if (rst || !bus.wb_cyc_o || !bus.wb_stb_o || bus.wb_ack_i ||
                $urandom_range(99) >= ack_pct) begin
                bus.wb_ack_i = 1'b0;
            end else begin
                bus.wb_ack_i = 1'b1;
                beats_seen++;
                if (bus.wb_we_o) mem[bus.wb_addr_o] = bus.wb_dat_o;
                else bus.wb_dat_i =
                    (mem.exists(bus.wb_addr_o) ? mem[bus.wb_addr_o]
                                               : dflt(bus.wb_addr_o)) ^
                    (corrupt.exists(bus.wb_addr_o) ? 32'h0000_0100 : 32'h0);
                if (mon_en) begin
                    if (exp_q.size() == 0) begin
                        n_chk++;
                        n_fail++;
                        $display("FAIL unexpected_beat: got addr %h expected none",
                                 bus.wb_addr_o);
                    end else begin
                        e = exp_q.pop_front();
                        check("beat_we", 64'(bus.wb_we_o), 64'(e.we));
                        check("beat_addr", 64'(bus.wb_addr_o), 64'(e.addr));
                        check("beat_cti", 64'(bus.wb_cti_o), 64'(e.cti));
                        check("beat_sel", 64'(bus.wb_sel_o), 64'(4'hF));
                        if (e.we) check("beat_wdat", 64'(bus.wb_dat_o), 64'(e.dat));
                        gap_st = e.gap ? 1 : 0;
                    end
                end
            end
        end
    end

    task automatic model(input logic [1:0] md, input logic pt,
                         input logic [31:0] sd, input logic [25:0] ba,
                         input logic [3:0] bl, input logic [15:0] nb,
                         output int exp_err, output logic [25:0] exp_first,
                         output int n_beats);
        int          eb;
        logic [31:0] l;
        logic [31:0] rv;
        logic [25:0] a;
        beat_t       e;
        eb = (bl == 0) ? 1 : int'(bl);
        exp_err = 0;
        exp_first = '0;
        n_beats = 0;
        for (int pass = 0; pass < 2; pass++) begin
            if (pass == 0 && md == 2'd1) continue;
            if (pass == 1 && md == 2'd0) continue;
            a = {ba[25:2], 2'b00};
            l = (sd == 0) ? 32'h1 : sd;
            for (int b = 0; b < int'(nb); b++) begin
                for (int i = 0; i < eb; i++) begin
                    e.we   = pass == 0;
                    e.addr = a;
                    e.dat  = pt ? l : {6'b0, a};
                    e.cti  = (eb == 1) ? 3'b000 : ((i == eb - 1) ? 3'b111 : 3'b010);
                    e.gap  = (i == eb - 1) && ((b < int'(nb) - 1) || pass == 0 && md != 2'd0);
                    if (pass == 0) ref_mem[a] = e.dat;
                    else begin
                        rv = (ref_mem.exists(a) ? ref_mem[a] : dflt(a)) ^
                             (corrupt.exists(a) ? 32'h0000_0100 : 32'h0);
                        if (rv != e.dat) begin
                            if (exp_err == 0) exp_first = a;
                            exp_err++;
                        end
                    end
                    exp_q.push_back(e);
                    n_beats++;
                    l = mulx(l);
                    a = a + 26'd4;
                end
            end
        end
    endtask

    task automatic kick(input logic [1:0] md, input logic pt,
                        input logic [31:0] sd, input logic [25:0] ba,
                        input logic [3:0] bl, input logic [15:0] nb);
        @(negedge clk);
        mode = md; pattern = pt; seed = sd;
        base_addr = ba; burst_len = bl; num_bursts = nb;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check("busy_after_start", 64'(busy), 64'(1));
        check("done_cleared", 64'(done), 64'(0));
    endtask

    task automatic wait_done();
        int n;
        n = 0;
        while (!done && n < 20000) begin
            @(negedge clk);
            n++;
        end
        check("done_set", 64'(done), 64'(1));
        check("busy_clear", 64'(busy), 64'(0));
    endtask

    task automatic run(input logic [1:0] md, input logic pt,
                       input logic [31:0] sd, input logic [25:0] ba,
                       input logic [3:0] bl, input logic [15:0] nb);
        int          exp_err, n_beats, b0, c0;
        logic [25:0] exp_first;
        model(md, pt, sd, ba, bl, nb, exp_err, exp_first, n_beats);
        b0 = beats_seen;
        c0 = cyc_cycles;
        kick(md, pt, sd, ba, bl, nb);
        wait_done();
        check("err_cnt", 64'(err_cnt), 64'(exp_err));
        check("first_err_addr", 64'(first_err_addr), 64'(exp_first));
        check("timeout_clear", 64'(timeout), 64'(0));
        check("beats_issued", 64'(beats_seen - b0), 64'(n_beats));
        check("queue_drained", 64'(exp_q.size()), 64'(0));
        if (nb == 0) check("no_bus_cycles", 64'(cyc_cycles - c0), 64'(0));
    endtask

    initial begin
        int n, b0, c0;
        repeat (3) @(negedge clk);
        check("rst_cyc", 64'(bus.wb_cyc_o), 64'(0));
        check("rst_stb", 64'(bus.wb_stb_o), 64'(0));
        check("rst_we", 64'(bus.wb_we_o), 64'(0));
        check("rst_addr", 64'(bus.wb_addr_o), 64'(0));
        check("rst_dat", 64'(bus.wb_dat_o), 64'(0));
        check("rst_sel", 64'(bus.wb_sel_o), 64'(0));
        check("rst_cti", 64'(bus.wb_cti_o), 64'(0));
        check("rst_busy", 64'(busy), 64'(0));
        check("rst_done", 64'(done), 64'(0));
        check("rst_timeout", 64'(timeout), 64'(0));
        check("rst_err_cnt", 64'(err_cnt), 64'(0));
        check("rst_first_err", 64'(first_err_addr), 64'(0));
        rst = 1'b0;

        ack_pct = 100;
        run(2'd2, 1'b0, 32'h0, 26'h100, 4'd4, 16'd2);
        run(2'd2, 1'b1, 32'h0, 26'h200, 4'd4, 16'd2);
        corrupt[26'h10C] = 1'b1;
        run(2'd2, 1'b0, 32'h0, 26'h100, 4'd4, 16'd2);
        corrupt[26'h114] = 1'b1;
        run(2'd2, 1'b0, 32'h0, 26'h100, 4'd4, 16'd2);
        corrupt.delete();
        run(2'd2, 1'b0, 32'h0, 26'h3FFFFF8, 4'd4, 16'd1);
        run(2'd2, 1'b1, 32'h1234_5678, 26'h400, 4'd0, 16'd3);
        run(2'd3, 1'b0, 32'h0, 26'h503, 4'd3, 16'd2);
        run(2'd1, 1'b0, 32'h0, 26'h800, 4'd2, 16'd2);

        // Slave that never acks
        ack_pct = 0;
        kick(2'd0, 1'b0, 32'h0, 26'h600, 4'd4, 16'd2);
        n = 0;
        while (!bus.wb_cyc_o && n < 50) begin @(negedge clk); n++; end
        n = 0;
        while (bus.wb_cyc_o && n < 100) begin @(negedge clk); n++; end
        check("timeout_cyc_len", 64'(n), 64'(16));
        wait_done();
        check("timeout_set", 64'(timeout), 64'(1));
        check("timeout_err_cnt", 64'(err_cnt), 64'(0));

        // Reset in the middle of a burst
        ack_pct = 100;
        model(2'd0, 1'b0, 32'h0, 26'h900, 4'd8, 16'd4, n, base_addr, c0);
        b0 = beats_seen;
        kick(2'd0, 1'b0, 32'h0, 26'h900, 4'd8, 16'd4);
        n = 0;
        while (beats_seen - b0 < 3 && n < 200) begin @(negedge clk); n++; end
        mon_en = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check("midrst_cyc", 64'(bus.wb_cyc_o), 64'(0));
        check("midrst_stb", 64'(bus.wb_stb_o), 64'(0));
        check("midrst_busy", 64'(busy), 64'(0));
        rst = 1'b0;
        c0 = cyc_cycles;
        repeat (5) @(negedge clk);
        check("midrst_quiet", 64'(cyc_cycles - c0), 64'(0));
        exp_q.delete();
        ref_mem = mem;
        mon_en = 1'b1;
        run(2'd2, 1'b0, 32'h0, 26'h900, 4'd0, 16'd0);
        run(2'd2, 1'b0, 32'h0, 26'h900, 4'd8, 16'd2);

        for (int t = 0; t < 24; t++) begin
            logic [25:0] rb;
            logic [3:0]  rbl;
            rb  = ($urandom_range(3) == 0) ? 26'h3FFFFF0 | 26'($urandom_range(15))
                                           : 26'($urandom_range(26'h3FFF));
            rbl = 4'($urandom_range(15));
            ack_pct = $urandom_range(60, 100);
            corrupt.delete();
            if ($urandom_range(1) == 1)
                for (int c = 0; c < 3; c++)
                    corrupt[{rb[25:2], 2'b00} + 26'(4 * $urandom_range(20))] = 1'b1;
            run(2'($urandom_range(3)), 1'($urandom_range(1)),
                ($urandom_range(3) == 0) ? 32'h0 : $urandom,
                rb, rbl, 16'($urandom_range(4)));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
